// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply sequencing controller:
// controller state encoding, default geometry and a width helper.
package matmul_pkg;

    // Default matrix dimension (number of A FIFOs / MACs)
    localparam int unsigned MATMUL_COLS       = 8;
    // Default element width in bits
    localparam int unsigned MATMUL_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILL    = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_DONE    = 2'd3
    } matseq_state_t;

    // $clog2 clamped to at least one bit so degenerate sizes still give legal vectors
    function automatic int unsigned clog2_min1(input int unsigned value);
        int unsigned w;
        w = $clog2(value);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/matmul_seq_ctrl_skew_gen.sv
// Diagonal read-skew generator: from the compute cycle counter, raises
// rdreq_a[i] for counter values i..i+COLS-1 and rdreq_b for 0..COLS-1,
// so each MAC column starts one cycle after its left neighbour.
module skew_gen #(
    parameter int unsigned COLS  = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             i_active,
    input  logic [CNT_W-1:0] i_cnt,
    output logic [COLS-1:0]  o_rdreq_a,
    output logic             o_rdreq_b
);

    // Window decode per A FIFO plus the shared B read window
    always_comb begin
        o_rdreq_a = '0;
        o_rdreq_b = i_active && (i_cnt < CNT_W'(COLS));
        for (int unsigned i = 0; i < COLS; i++) begin
            o_rdreq_a[i] = i_active
                        && (i_cnt >= CNT_W'(i))
                        && (i_cnt <  CNT_W'(i + COLS));
        end
    end

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Matrix-multiply sequencing controller. Loads COLS*COLS A elements
// (row-major, one A FIFO per row) followed by COLS B elements from a
// valid/ready stream into FIFOs, then drains them with a diagonal skew
// into COLS MACs and pulses done.
// Optional build macro: MATSEQ_EMPTY_CHECK_EN -- flags reads from an empty
// FIFO with a sticky err and aborts the job back to IDLE without done.
module matmul_seq_ctrl
    import matmul_pkg::*;
#(
    parameter int unsigned COLS       = MATMUL_COLS,
    parameter int unsigned DATA_WIDTH = MATMUL_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  ld_valid,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic                  ld_ready,
    output logic [DATA_WIDTH-1:0] fifo_data,
    output logic [COLS-1:0]       wrreq_a,
    output logic                  wrreq_b,
    input  logic [COLS-1:0]       wrfull_a,
    input  logic                  wrfull_b,
    output logic [COLS-1:0]       rdreq_a,
    output logic                  rdreq_b,
    input  logic [COLS-1:0]       rdempty_a,
    input  logic                  rdempty_b,
    output logic [COLS-1:0]       mac_en,
    output logic                  mac_clr,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned LD_BEATS = COLS * COLS + COLS;
    localparam int unsigned LD_W     = clog2_min1(LD_BEATS + 1);
    localparam int unsigned CMP_LAST = 2 * COLS - 2;
    localparam int unsigned CMP_W    = clog2_min1(2 * COLS);
    localparam int unsigned ROW_W    = clog2_min1(COLS + 1);
    localparam int unsigned COL_W    = clog2_min1(COLS);

    matseq_state_t r_state;
    matseq_state_t w_state_nxt;

    logic [LD_W-1:0]  r_ld_cnt;
    // Row index COLS selects the B FIFO; row/col shadow the beat count so
    // no divider is needed to find the target FIFO.
    logic [ROW_W-1:0] r_ld_row;
    logic [COL_W-1:0] r_ld_col;
    logic [CMP_W-1:0] r_cmp_cnt;
    logic [COLS-1:0]  r_mac_en;

    logic             w_is_b;
    logic             w_tgt_full;
    logic             w_ld_ready;
    logic             w_accept;
    logic             w_ld_last;
    logic             w_cmp_last;
    logic             w_compute;
    logic [COLS-1:0]  w_rdreq_a;
    logic             w_rdreq_b;
    logic             w_empty_hit;

    assign w_is_b     = (r_ld_row == ROW_W'(COLS));
    assign w_ld_last  = (r_ld_cnt == LD_W'(LD_BEATS - 1));
    assign w_cmp_last = (r_cmp_cnt == CMP_W'(CMP_LAST));
    assign w_compute  = (r_state == ST_COMPUTE);

    // Target-FIFO full select, load handshake and write-request routing
    always_comb begin
        w_tgt_full = wrfull_b;
        for (int unsigned i = 0; i < COLS; i++) begin
            if (r_ld_row == ROW_W'(i)) begin
                w_tgt_full = wrfull_a[i];
            end
        end
        w_ld_ready = (r_state == ST_FILL) && !w_tgt_full;
        w_accept   = ld_valid && w_ld_ready;
        wrreq_a    = '0;
        for (int unsigned i = 0; i < COLS; i++) begin
            wrreq_a[i] = w_accept && (r_ld_row == ROW_W'(i));
        end
        wrreq_b    = w_accept && w_is_b;
    end

    skew_gen #(
        .COLS  (COLS),
        .CNT_W (CMP_W)
    ) u_skew_gen (
        .i_active  (w_compute),
        .i_cnt     (r_cmp_cnt),
        .o_rdreq_a (w_rdreq_a),
        .o_rdreq_b (w_rdreq_b)
    );

`ifdef MATSEQ_EMPTY_CHECK_EN
    logic r_err;

    assign w_empty_hit = (|(w_rdreq_a & rdempty_a)) || (w_rdreq_b && rdempty_b);

    // Sticky empty-read error, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_empty_hit) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    logic w_unused_empty;

    assign w_unused_empty = ^{rdempty_a, rdempty_b};
    assign w_empty_hit    = 1'b0;
    assign err            = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and one-cycle control pulses
    always_comb begin
        w_state_nxt = r_state;
        mac_clr     = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_FILL;
                    mac_clr     = 1'b1;
                end
            end
            ST_FILL: begin
                if (w_accept && w_ld_last) begin
                    w_state_nxt = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                if (w_empty_hit) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_cmp_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Load beat counter with row/column routing indices; held while stalled
    always_ff @(posedge clk) begin
        if (rst || (r_state != ST_FILL)) begin
            r_ld_cnt <= '0;
            r_ld_row <= '0;
            r_ld_col <= '0;
        end else if (w_accept) begin
            r_ld_cnt <= r_ld_cnt + LD_W'(1);
            if (r_ld_col == COL_W'(COLS - 1)) begin
                r_ld_col <= '0;
                r_ld_row <= r_ld_row + ROW_W'(1);
            end else begin
                r_ld_col <= r_ld_col + COL_W'(1);
            end
        end
    end

    // Compute cycle counter; only runs while COMPUTE persists
    always_ff @(posedge clk) begin
        if (rst || !(w_compute && (w_state_nxt == ST_COMPUTE))) begin
            r_cmp_cnt <= '0;
        end else begin
            r_cmp_cnt <= r_cmp_cnt + CMP_W'(1);
        end
    end

    // MAC enable follows the A read by one cycle to match FIFO read latency
    always_ff @(posedge clk) begin
        if (rst || w_empty_hit) begin
            r_mac_en <= '0;
        end else begin
            r_mac_en <= w_rdreq_a;
        end
    end

    assign ld_ready  = w_ld_ready;
    assign fifo_data = ld_data;
    assign rdreq_a   = w_rdreq_a;
    assign rdreq_b   = w_rdreq_b;
    assign mac_en    = r_mac_en;
    assign busy      = (r_state != ST_IDLE);

endmodule
